uart_tx_controller: RTL and testbench

- Transmit-side sequencer for the UART. It consumes the 16x oversampling tick from the baud rate generator and serialises one byte per frame onto the TX line: start bit, DATA_BITS data bits LSB first, then one stop bit.
- Accepts bytes through a valid/ready handshake from the transmit FIFO or debug unit, and pulses done at the end of each frame.
- Sits beside the baud rate generator inside the UART top; the tick is an input, so there is no internal baud generation.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_controller.sv | 125 ++++++++++++
 tb/tb_uart_tx_controller.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and the oversampling ratio used by TX, RX and the baud generator.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_e;

  localparam int NUM_TICKS         = 16;
  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: serialises start, DATA_BITS data bits (LSB first) and a stop bit
// using the 16x baud tick. Outputs decode only from registers.
//
// state | meaning
// IDLE  | line high, ready for a byte
// START | line low for NUM_TICKS ticks
// DATA  | line = shift[0], one bit per NUM_TICKS ticks
// STOP  | line high for STOP_TICKS ticks, then done pulse
module uart_tx_controller #(
  parameter int DATA_BITS  = uart_pkg::DEFAULT_DATA_BITS,
  parameter int NUM_TICKS  = uart_pkg::NUM_TICKS,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_tx_done
);
  import uart_pkg::*;

  localparam int MAX_TICKS = (NUM_TICKS > STOP_TICKS) ? NUM_TICKS : STOP_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] NT_LAST  = TW'(NUM_TICKS - 1);
  localparam logic [TW-1:0] ST_LAST  = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  tx_state_e            state, state_nxt;
  logic [TW-1:0]        tick_cnt, tick_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 done, done_nxt;
  logic                 accept;

  // Ready is held off during the done cycle so a new byte lands the cycle after it.
  assign o_ready   = (state == IDLE) && !done;
  assign accept    = o_ready && i_valid;
  assign o_tx_done = done;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_nxt = i_data;
          tick_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_cnt == NT_LAST) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = DATA;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_cnt == NT_LAST) begin
            tick_nxt  = '0;
            shift_nxt = shift >> 1;
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (tick_cnt == ST_LAST) begin
            tick_nxt  = '0;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_tx = 1'b1;
    case (state)
      START:   o_tx = 1'b0;
      DATA:    o_tx = shift[0];
      default: o_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Self-checking bench for uart_tx_controller: per-tick line sampling against a queue of expected bit segments.
module tb_uart_tx_controller;

  localparam int NT = 16;

  typedef struct {
    logic lvl;
    int   ticks;
  } seg_t;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick  = 1'b0;
  logic       v16     = 1'b0;
  logic       v32     = 1'b0;
  logic [7:0] i_data  = 8'h00;
  logic       tx16, rdy16, done16;
  logic       tx32, rdy32, done32;
  logic       sel32   = 1'b0;
  logic       tx_s, ready_s, done_s;

  int checks = 0;
  int passed = 0;
  seg_t exp_q[$];

  assign tx_s    = sel32 ? tx32  : tx16;
  assign ready_s = sel32 ? rdy32 : rdy16;
  assign done_s  = sel32 ? done32 : done16;

  uart_tx_controller #(.DATA_BITS(8), .NUM_TICKS(16), .STOP_TICKS(16)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_valid(v16),
    .i_data(i_data), .o_ready(rdy16), .o_tx(tx16), .o_tx_done(done16));

  uart_tx_controller #(.DATA_BITS(8), .NUM_TICKS(16), .STOP_TICKS(32)) dut32 (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick), .i_valid(v32),
    .i_data(i_data), .o_ready(rdy32), .o_tx(tx32), .o_tx_done(done32));

  always #5 i_clock = ~i_clock;

  // One tick every fourth cycle, changed just after the rising edge.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge i_clock);
      #1;
      i_tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  task automatic set_valid(input logic v);
    if (sel32) v32 = v;
    else v16 = v;
  endtask

  task automatic push_frame(input logic [7:0] d, input int stop_ticks);
    exp_q.push_back('{1'b0, NT});
    for (int i = 0; i < 8; i++) exp_q.push_back('{d[i], NT});
    exp_q.push_back('{1'b1, stop_ticks});
  endtask

  // Entered between edges (normally at a falling edge); returns at a falling edge with the DUT idle.
  task automatic run_frame(input string name, input logic [7:0] d, input logic [7:0] d_after,
                           input bit keep_valid, input int stop_ticks, input int inject_tick,
                           output int wait_cycles);
    int   cyc, ticks_seen, early, seg_n, seg_i;
    bit   injected, inj_active;
    logic lo, hi;
    seg_t seg;
    i_data = d;
    set_valid(1'b1);
    wait_cycles = 0;
    while (ready_s !== 1'b1 && wait_cycles < 2000) begin
      @(negedge i_clock);
      wait_cycles++;
    end
    checks++;
    if (ready_s !== 1'b1) begin
      $display("FAIL %s accept: o_ready=%b, want 1", name, ready_s);
      set_valid(1'b0);
      return;
    end else passed++;
    @(posedge i_clock);
    #1;
    i_data = d_after;
    if (!keep_valid) set_valid(1'b0);
    push_frame(d, stop_ticks);
    cyc = 0; ticks_seen = 0; early = 0; seg_n = 0; seg_i = 0;
    injected = 0; inj_active = 0; lo = 1'b1; hi = 1'b0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      @(negedge i_clock);
      cyc++;
      if (inj_active) begin
        set_valid(1'b0);
        inj_active = 0;
      end
      if (inject_tick > 0 && !injected && ticks_seen == inject_tick) begin
        i_data = 8'h3C;
        set_valid(1'b1);
        injected = 1;
        inj_active = 1;
      end
      if (done_s !== 1'b0) early++;
      if (i_tick) begin
        seg = exp_q[0];
        lo = lo & tx_s;
        hi = hi | tx_s;
        seg_n++;
        ticks_seen++;
        if (seg_n == seg.ticks) begin
          checks++;
          if ({lo, hi} !== {seg.lvl, seg.lvl})
            $display("FAIL %s seg%0d: line min/max=%b/%b, want %b for %0d ticks",
                     name, seg_i, lo, hi, seg.lvl, seg.ticks);
          else passed++;
          void'(exp_q.pop_front());
          seg_n = 0; seg_i++; lo = 1'b1; hi = 1'b0;
        end
      end
    end
    if (inj_active) set_valid(1'b0);
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s timeout: %0d segments left, want 0", name, exp_q.size());
    else passed++;
    exp_q.delete();
    checks++;
    if (early !== 0) $display("FAIL %s early_done: %0d cycles with done, want 0", name, early);
    else passed++;
    @(negedge i_clock);
    checks++;
    if ({done_s, ready_s} !== 2'b10)
      $display("FAIL %s done_pulse: done,ready=%b%b, want 10 after tick %0d", name, done_s, ready_s, ticks_seen);
    else passed++;
    @(negedge i_clock);
    checks++;
    if ({done_s, ready_s, tx_s} !== 3'b011)
      $display("FAIL %s ready_after_done: done,ready,tx=%b%b%b, want 011", name, done_s, ready_s, tx_s);
    else passed++;
  endtask

  task automatic test_reset();
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if ({tx16, rdy16, done16, tx32, rdy32, done32} !== 6'b110110)
      $display("FAIL reset_async: tx,ready,done=%b%b%b/%b%b%b, want 110/110",
               tx16, rdy16, done16, tx32, rdy32, done32);
    else passed++;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    repeat (100) @(negedge i_clock);
    checks++;
    if ({tx16, rdy16, done16, tx32, rdy32, done32} !== 6'b110110)
      $display("FAIL reset_idle: tx,ready,done=%b%b%b/%b%b%b, want 110/110",
               tx16, rdy16, done16, tx32, rdy32, done32);
    else passed++;
  endtask

  task automatic test_single_byte();
    int w;
    run_frame("a5", 8'hA5, 8'hA5, 1'b0, 16, 0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    run_frame("b2b_00", 8'h00, 8'hFF, 1'b1, 16, 0, w);
    run_frame("b2b_ff", 8'hFF, 8'hFF, 1'b0, 16, 0, w);
    checks++;
    if (w !== 0) $display("FAIL b2b_gap: %0d idle cycles before second accept, want 0", w);
    else passed++;
  endtask

  task automatic test_handshake();
    int w, bad;
    run_frame("hs", 8'h96, 8'h96, 1'b0, 16, 40, w);
    bad = 0;
    repeat (200) begin
      @(negedge i_clock);
      if ({ready_s, tx_s, done_s} !== 3'b110) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL hs_no_second_frame: %0d non-idle cycles, want 0", bad);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int w, cyc, ticks, bad;
    i_data = 8'h55;
    set_valid(1'b1);
    cyc = 0;
    while (ready_s !== 1'b1 && cyc < 2000) begin
      @(negedge i_clock);
      cyc++;
    end
    @(posedge i_clock);
    #1;
    set_valid(1'b0);
    ticks = 0;
    cyc = 0;
    while (ticks < 72 && cyc < 2000) begin
      @(negedge i_clock);
      cyc++;
      if (i_tick) ticks++;
    end
    checks++;
    if (tx_s !== 1'b0) $display("FAIL rst_mid_bit3: tx=%b, want 0", tx_s);
    else passed++;
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if ({tx_s, ready_s, done_s} !== 3'b110)
      $display("FAIL rst_mid_async: tx,ready,done=%b%b%b, want 110", tx_s, ready_s, done_s);
    else passed++;
    @(negedge i_clock);
    i_reset = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge i_clock);
      if ({tx_s, ready_s, done_s} !== 3'b110) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL rst_mid_abandon: %0d non-idle cycles, want 0", bad);
    else passed++;
    run_frame("rst_0f", 8'h0F, 8'h0F, 1'b0, 16, 0, w);
  endtask

  task automatic test_stop_length();
    int w;
    sel32 = 1'b1;
    run_frame("stop32", 8'h81, 8'h81, 1'b0, 32, 0, w);
    sel32 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_handshake();
    test_reset_mid_frame();
    test_stop_length();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
